// File: rtl/dnn_mem_bridge.sv
// Bridge from one accelerator memory port to a system memory port: base-offset address
// translation, valid/ready handshake, one-word read buffer, write-through.
// Optional hit/miss statistics counters are enabled by defining DNN_BRIDGE_STATS_EN.
module dnn_mem_bridge #(
  parameter int BYTE_ADDR = 1,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       base_addr,
  input  logic              flush,
  input  logic              acc_req,
  input  logic              acc_wen,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [31:0]       acc_wdata,
  output logic [31:0]       acc_rdata,
  output logic              acc_ack,
  output logic              stall,
  output logic              mem_valid,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int IDX_W = (BYTE_ADDR != 0) ? ADDR_W - 2 : ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;

  logic [IDX_W-1:0] word_idx;
  logic [31:0]      word_off;
  logic             accept;
  logic             rd_hit;
  logic             mem_done;

  logic             wen_q;
  logic [IDX_W-1:0] word_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             flushed_q;

  logic             buf_valid;
  logic [IDX_W-1:0] buf_tag;
  logic [31:0]      buf_data;

  // Byte addressing drops the two in-word offset bits; word addressing uses all bits.
  generate
    if (BYTE_ADDR != 0) begin : g_byte_addr
      logic unused_addr_lsbs;
      assign word_idx         = acc_addr[ADDR_W-1:2];
      assign unused_addr_lsbs = ^acc_addr[1:0];
    end else begin : g_word_addr
      assign word_idx = acc_addr;
    end
  endgenerate

  assign word_off = 32'(word_idx) << 2;
  assign accept   = acc_req && ((state == IDLE) || (state == DONE));
  assign rd_hit   = !acc_wen && buf_valid && (buf_tag == word_idx) && !flush;
  assign mem_done = (state == BUSY) && mem_ready;

  // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_nxt = rd_hit ? DONE : BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request latch: address, direction and data are frozen for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q     <= 1'b0;
      word_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      flushed_q <= 1'b0;
    end else begin
      if (accept) begin
        wen_q     <= acc_wen;
        word_q    <= word_idx;
        addr_q    <= base_addr + word_off;
        wdata_q   <= acc_wdata;
        flushed_q <= 1'b0;
      end else if ((state == BUSY) && flush) begin
        flushed_q <= 1'b1;
      end
    end
  end

  // NOTE: the one-word buffer is reset like any flop; valid alone gates use, but a reset
  // data word keeps acc_rdata deterministic and costs nothing at this size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
      rdata_q   <= '0;
    end else begin
      if (accept && rd_hit) begin
        rdata_q <= buf_data;
      end
      if (mem_done) begin
        if (!wen_q) begin
          buf_data  <= mem_rdata;
          buf_tag   <= word_q;
          rdata_q   <= mem_rdata;
          buf_valid <= !(flushed_q || flush);
        end else if (buf_valid && (buf_tag == word_q)) begin
          buf_data <= wdata_q;
        end
      end
      // A flush in any state wins over a same-cycle fill.
      if (flush) begin
        buf_valid <= 1'b0;
      end
    end
  end

`ifdef DNN_BRIDGE_STATS_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (flush) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (accept && !acc_wen) begin
      if (rd_hit) begin
        if (hit_q != 32'hFFFF_FFFF) hit_q <= hit_q + 32'd1;
      end else begin
        if (miss_q != 32'hFFFF_FFFF) miss_q <= miss_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

  assign mem_valid = (state == BUSY);
  assign stall     = (state == BUSY);
  assign mem_write = (state == BUSY) && wen_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign acc_ack   = (state == DONE);
  assign acc_rdata = rdata_q;

endmodule

// File: tb/tb_dnn_mem_bridge.sv
// Self-checking bench for dnn_mem_bridge: directed transactions scored against a
// word-buffer model, plus literal expectations from hand-worked scenarios.
module tb_dnn_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] base_addr;
  logic        flush;
  logic        acc_req;
  logic        acc_wen;
  logic [15:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [31:0] acc_rdata;
  logic        acc_ack;
  logic        stall;
  logic        mem_valid;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

`ifdef DNN_BRIDGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  dnn_mem_bridge dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .base_addr (base_addr),
    .flush     (flush),
    .acc_req   (acc_req),
    .acc_wen   (acc_wen),
    .acc_addr  (acc_addr),
    .acc_wdata (acc_wdata),
    .acc_rdata (acc_rdata),
    .acc_ack   (acc_ack),
    .stall     (stall),
    .mem_valid (mem_valid),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model: last read word remembered by word index, plus hit/miss tallies.
  logic        m_valid;
  logic [13:0] m_tag;
  logic [31:0] m_data;
  logic [31:0] m_rdata;
  logic [31:0] m_hits;
  logic [31:0] m_misses;

  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  logic        exp_write;
  logic        exp_miss;
  bit          chk_en = 1'b0;

  int          lat;
  logic [31:0] seen_addr;
  logic        seen_valid;
  logic        seen_write;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_flush();
    m_valid  = 1'b0;
    m_hits   = '0;
    m_misses = '0;
  endtask

  // One accelerator transaction. Entered at posedge+1 with the DUT idle or acknowledging;
  // leaves acc_req asserted so the caller may issue a back-to-back request.
  // flush_cyc: -1 none, 0 acceptance cycle, k>0 the k-th cycle with mem_valid high.
  task automatic txn(input logic wen, input logic [15:0] addr, input logic [31:0] wdata,
                     input logic [31:0] base, input int waits, input logic [31:0] rd,
                     input int flush_cyc, output int lat_o, output logic [31:0] sa,
                     output logic sv, output logic sw);
    logic [13:0] word;
    logic        hit;
    logic        flush_now;
    logic        flush_pend;
    logic        flushed;
    int          busy;
    word      = addr[15:2];
    flush_now = (flush_cyc == 0);
    hit       = !wen && m_valid && (m_tag == word) && !flush_now;
    exp_addr  = base + {16'h0, word, 2'b00};
    exp_write = wen;
    exp_wdata = wdata;
    exp_miss  = !hit;
    acc_req   = 1'b1;
    acc_wen   = wen;
    acc_addr  = addr;
    acc_wdata = wdata;
    base_addr = base;
    flush     = flush_now;
    lat_o = 0; busy = 0; flushed = 1'b0; flush_pend = 1'b0;
    sa = '0; sv = 1'b0; sw = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      if (n == 1) begin
        if (!wen) begin
          if (hit) m_hits = sat_inc(m_hits);
          else     m_misses = sat_inc(m_misses);
        end
        if (flush_now) model_flush();
      end
      if (flush_pend) begin
        model_flush();
        flushed    = 1'b1;
        flush_pend = 1'b0;
      end
      #1;
      flush     = 1'b0;
      mem_ready = 1'b0;
      if (acc_ack) begin
        lat_o = n;
        break;
      end
      if (mem_valid) begin
        sv = 1'b1;
        sa = mem_addr;
        sw = mem_write;
        busy++;
        if (flush_cyc == busy) begin
          flush      = 1'b1;
          flush_pend = 1'b1;
        end
        if (busy == waits + 1) begin
          mem_ready = 1'b1;
          mem_rdata = rd;
        end
      end
    end
    check("ack_latency", 32'(lat_o), hit ? 32'd1 : 32'(2 + waits));
    if (!wen) begin
      if (hit) begin
        m_rdata = m_data;
      end else begin
        m_data  = rd;
        m_tag   = word;
        m_valid = !flushed;
        m_rdata = rd;
      end
    end else if (m_valid && (m_tag == word)) begin
      m_data = wdata;
    end
    check("ack_rdata", acc_rdata, m_rdata);
  endtask

  task automatic idle(input int n, input bit stray);
    acc_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (stray) begin
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
      end
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
    end
  endtask

  task automatic pulse_flush();
    acc_req = 1'b0;
    flush   = 1'b1;
    @(posedge clk);
    model_flush();
    #1;
    flush = 1'b0;
  endtask

  // Per-cycle comparison of every observable output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("hit_cnt", hit_cnt, STATS ? m_hits : 32'h0);
      check("miss_cnt", miss_cnt, STATS ? m_misses : 32'h0);
      check("acc_rdata_hold", acc_rdata, m_rdata);
      check("stall_vs_valid", 32'(stall), 32'(mem_valid));
      if (mem_valid) begin
        check("mem_valid_only_on_miss", 32'd1, 32'(exp_miss));
        check("mem_addr", mem_addr, exp_addr);
        check("mem_write", 32'(mem_write), 32'(exp_write));
        if (exp_write) check("mem_wdata", mem_wdata, exp_wdata);
      end
    end
  end

  initial begin
    base_addr = '0; flush = 1'b0; acc_req = 1'b0; acc_wen = 1'b0;
    acc_addr = '0; acc_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    m_valid = 1'b0; m_tag = '0; m_data = '0; m_rdata = '0; m_hits = '0; m_misses = '0;
    exp_addr = '0; exp_wdata = '0; exp_write = 1'b0; exp_miss = 1'b1;

    #12;
    check("rst_acc_ack", 32'(acc_ack), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_acc_rdata", acc_rdata, 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    idle(1, 1'b0);

    // Read miss with two wait cycles, then a back-to-back hit in the same word.
    txn(1'b0, 16'h0008, 32'h0, 32'h100, 2, 32'hDEADBEEF, -1, lat, seen_addr, seen_valid, seen_write);
    check("t1_latency", 32'(lat), 32'd4);
    check("t1_mem_addr", seen_addr, 32'h108);
    check("t1_mem_write", 32'(seen_write), 32'd0);
    check("t1_rdata", acc_rdata, 32'hDEADBEEF);
    txn(1'b0, 16'h000B, 32'h0, 32'h100, 0, 32'h0, -1, lat, seen_addr, seen_valid, seen_write);
    check("t2_latency", 32'(lat), 32'd1);
    check("t2_no_mem_valid", 32'(seen_valid), 32'd0);
    check("t2_rdata", acc_rdata, 32'hDEADBEEF);
    idle(1, 1'b0);

    // Write-through to the buffered word, then a hit returning the new data.
    txn(1'b1, 16'h0008, 32'h12345678, 32'h100, 0, 32'h0, -1, lat, seen_addr, seen_valid, seen_write);
    check("t3_latency", 32'(lat), 32'd2);
    check("t3_mem_write", 32'(seen_write), 32'd1);
    check("t3_rdata_kept", acc_rdata, 32'hDEADBEEF);
    txn(1'b0, 16'h0008, 32'h0, 32'h100, 0, 32'h0, -1, lat, seen_addr, seen_valid, seen_write);
    check("t3_hit_no_mem", 32'(seen_valid), 32'd0);
    check("t3_hit_rdata", acc_rdata, 32'h12345678);
    idle(2, 1'b1);

    // Slow write to another word leaves the buffer alone; stray mem_ready was ignored.
    txn(1'b1, 16'h0040, 32'hCAFEF00D, 32'h100, 3, 32'h0, -1, lat, seen_addr, seen_valid, seen_write);
    check("t3b_mem_addr", seen_addr, 32'h140);
    check("t3b_latency", 32'(lat), 32'd5);
    txn(1'b0, 16'h0008, 32'h0, 32'h100, 0, 32'h0, -1, lat, seen_addr, seen_valid, seen_write);
    check("t3b_hit_rdata", acc_rdata, 32'h12345678);
    idle(1, 1'b0);

    // Flush during the miss: completes, but the word is not retained.
    txn(1'b0, 16'h0010, 32'h0, 32'h100, 3, 32'hA5A50001, 2, lat, seen_addr, seen_valid, seen_write);
    check("t4_latency", 32'(lat), 32'd5);
    check("t4_rdata", acc_rdata, 32'hA5A50001);
    txn(1'b0, 16'h0010, 32'h0, 32'h100, 1, 32'hA5A50002, -1, lat, seen_addr, seen_valid, seen_write);
    check("t4_refetch_miss", 32'(seen_valid), 32'd1);
    txn(1'b0, 16'h0012, 32'h0, 32'h100, 0, 32'h0, -1, lat, seen_addr, seen_valid, seen_write);
    check("t4_hit_rdata", acc_rdata, 32'hA5A50002);
    idle(1, 1'b0);

    // Flush in the acceptance cycle forces a miss; address arithmetic wraps at 32 bits.
    txn(1'b0, 16'h0010, 32'h0, 32'h100, 0, 32'h11110000, 0, lat, seen_addr, seen_valid, seen_write);
    check("t5_forced_miss", 32'(seen_valid), 32'd1);
    txn(1'b0, 16'h0014, 32'h0, 32'hFFFF_FFF0, 0, 32'h22220000, -1, lat, seen_addr, seen_valid, seen_write);
    check("t5_wrap_addr", seen_addr, 32'h0000_0004);
    idle(1, 1'b0);

    // One miss plus three hits, then a flush clearing the statistics.
    pulse_flush();
    txn(1'b0, 16'h0020, 32'h0, 32'h100, 1, 32'h33330000, -1, lat, seen_addr, seen_valid, seen_write);
    txn(1'b0, 16'h0020, 32'h0, 32'h100, 0, 32'h0, -1, lat, seen_addr, seen_valid, seen_write);
    txn(1'b0, 16'h0021, 32'h0, 32'h100, 0, 32'h0, -1, lat, seen_addr, seen_valid, seen_write);
    txn(1'b0, 16'h0023, 32'h0, 32'h100, 0, 32'h0, -1, lat, seen_addr, seen_valid, seen_write);
    idle(1, 1'b0);
    check("t6_hit_cnt", hit_cnt, STATS ? 32'd3 : 32'd0);
    check("t6_miss_cnt", miss_cnt, STATS ? 32'd1 : 32'd0);
    pulse_flush();
    idle(1, 1'b0);
    check("t6_hit_cnt_flushed", hit_cnt, 32'd0);
    check("t6_miss_cnt_flushed", miss_cnt, 32'd0);

    // Asynchronous reset in the middle of a memory transaction.
    txn(1'b0, 16'h0020, 32'h0, 32'h100, 0, 32'h44440000, -1, lat, seen_addr, seen_valid, seen_write);
    idle(1, 1'b0);
    chk_en    = 1'b0;
    acc_req   = 1'b1;
    acc_wen   = 1'b0;
    acc_addr  = 16'h0030;
    base_addr = 32'h100;
    @(posedge clk);
    #1;
    check("t7_pre_mem_valid", 32'(mem_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_mem_valid_drop", 32'(mem_valid), 32'd0);
    check("t7_stall_drop", 32'(stall), 32'd0);
    check("t7_ack_low", 32'(acc_ack), 32'd0);
    check("t7_rdata_reset", acc_rdata, 32'd0);
    acc_req = 1'b0;
    m_valid = 1'b0; m_hits = '0; m_misses = '0; m_rdata = '0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    idle(1, 1'b0);
    txn(1'b0, 16'h0020, 32'h0, 32'h100, 0, 32'h55550000, -1, lat, seen_addr, seen_valid, seen_write);
    check("t7_post_reset_miss", 32'(seen_valid), 32'd1);
    idle(2, 1'b0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dnn_mem_bridge.md
Name: dnn_mem_bridge

Overview:
- Sits between one accelerator memory port (input, weight or output) and the matching system memory port.
- Converts the accelerator's 16-bit local address into a 32-bit word-aligned system address by adding a base offset.
- Runs the mem_valid/mem_ready handshake.
- Keeps a one-entry word buffer so repeated reads of the same word skip the memory. Writes are write-through.

Parameters:
- BYTE_ADDR, 1, 1 = acc_addr is a byte address (word = acc_addr[15:2]); 0 = acc_addr is a word index.
- ADDR_W, 16, width of acc_addr.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- base_addr  input  32  system byte address of word 0; sampled at request acceptance
- flush  input  1  one-cycle pulse that invalidates the word buffer (issued at accelerator start)
- acc_req  input  1  accelerator request
- acc_wen  input  1  1 = write, 0 = read; qualified by acc_req
- acc_addr  input  ADDR_W  local address
- acc_wdata  input  32  write data
- acc_rdata  output  32  read data; valid when acc_ack=1
- acc_ack  output  1  one-cycle completion pulse
- stall  output  1  high while a memory transaction is outstanding
- mem_valid  output  1  system request
- mem_write  output  1  system write enable
- mem_addr  output  32  system byte address, word aligned
- mem_wdata  output  32  system write data
- mem_ready  input  1  system handshake completion
- mem_rdata  input  32  system read data; valid in the mem_ready cycle
- hit_cnt  output  32  buffer hit count (optional feature)
- miss_cnt  output  32  buffer miss count (optional feature)

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, buffer invalid. Reset is asynchronous; mem_valid drops in the same instant, and an in-flight transaction is abandoned without acc_ack.
- FSM has three states:
  - IDLE: nothing in progress.
  - BUSY: mem_valid=1, stall=1.
  - DONE: acc_ack=1 for exactly one cycle.
- Request acceptance:
  - A request is accepted when acc_req=1 in IDLE or DONE. DONE acceptance allows back-to-back requests.
  - acc_req in BUSY is ignored. The accelerator must hold acc_req until it sees acc_ack.
  - On acceptance, addr, wen, wdata and base_addr are latched.
- Address arithmetic:
  - BYTE_ADDR=1: mem_addr = base_addr + {acc_addr[15:2], 2'b00}.
  - BYTE_ADDR=0: mem_addr = base_addr + (acc_addr << 2).
  - 32-bit wrap, with no overflow flag.
  - Tag = latched word index.
- Read hit (buffer valid, tag equal, flush=0): next state DONE. acc_rdata = buffered word. Latency 1 cycle.
- Read miss: next state BUSY.
  - mem_valid=1 and mem_write=0; mem_addr is held stable until mem_ready.
  - In the mem_ready cycle: capture mem_rdata into the buffer and acc_rdata, set the buffer valid, load the tag, and go to DONE.
  - Latency = 2 + the number of wait cycles before mem_ready.
- Write (always goes to memory): next state BUSY with mem_write=1; mem_wdata = latched wdata, held stable until mem_ready.
  - On mem_ready: if the buffer is valid and the tag is equal, update the buffered word with wdata.
  - Go to DONE. acc_rdata is unchanged.
- mem_ready while mem_valid=0 is ignored. mem_valid never drops before mem_ready.
- acc_rdata holds its last read value until the next read completes.
- Flush rules:
  - flush clears buffer valid in any state.
  - flush in the acceptance cycle forces a miss.
  - flush during BUSY lets the transaction complete, but the fill or write update does not validate the buffer (flush wins).
- From DONE with no new acc_req, go to IDLE.

Optional Feature:
- Macro DNN_BRIDGE_STATS_EN.
- Defined:
  - hit_cnt increments on each accepted read hit; miss_cnt increments on each accepted read miss.
  - Writes are not counted.
  - Both counters are 32-bit and saturate at 32'hFFFF_FFFF.
  - Both clear on flush; flush has priority over the same-cycle increment.
- Undefined: hit_cnt and miss_cnt are tied to 0, with no counter flops.

Test Plan:
- Reset release, base_addr=32'h100, read acc_addr=16'h0008, mem_ready after 2 wait cycles with mem_rdata=32'hDEADBEEF -> mem_addr=32'h108, mem_write=0, acc_ack 4 cycles after acceptance, acc_rdata=32'hDEADBEEF.
- Back-to-back reads of 16'h0008 then 16'h000B -> second is a hit: no mem_valid, acc_ack 1 cycle after acceptance, rdata=32'hDEADBEEF.
- Write 16'h0008 with wdata=32'h12345678, mem_ready immediate, then read 16'h0008 -> mem_write=1 and mem_wdata held until ready; the following read hits and returns 32'h12345678.
- flush pulse asserted during BUSY of a read miss -> transaction completes with acc_ack; the next read of the same word issues mem_valid (miss).
- rst_n asserted while mem_valid=1 -> mem_valid, acc_ack and stall go to 0 immediately; the next read after reset is a miss.
- With DNN_BRIDGE_STATS_EN: 1 miss + 3 hits -> miss_cnt=1, hit_cnt=3; flush -> both 0. Without the macro: both outputs stay 0.
